// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 raster counters, coordinate decodes and delayed hsync/vsync.
// Define VGA_TIMING_TEST_PATTERN_EN to add registered colour-bar outputs tp_r/tp_g/tp_b.
module vga_timing_gen #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter bit SYNC_POL   = 1'b0,
    parameter int SYNC_DELAY = 2
) (
    input  logic        clk_25,
    input  logic        rst,
    output logic [9:0]  sx,
    output logic [9:0]  sy,
    output logic        active_pixel,
    output logic        line_start,
    output logic        frame_start,
    output logic        hsync,
    output logic        vsync,
`ifdef VGA_TIMING_TEST_PATTERN_EN
    output logic [3:0]  tp_r,
    output logic [3:0]  tp_g,
    output logic [3:0]  tp_b,
`endif
    output logic [15:0] frame_cnt
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_total_chk
        $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
    end
    if (SYNC_DELAY < 0 || SYNC_DELAY > 7) begin : g_delay_chk
        $error("vga_timing_gen: SYNC_DELAY must be in 0..7");
    end

    logic [9:0]  sx_q, sx_d, sy_q, sy_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic        h_end, v_end, hs_raw, vs_raw;

    always_comb begin
        h_end       = sx_q == H_LAST;
        v_end       = sy_q == V_LAST;
        sx_d        = h_end ? 10'd0 : sx_q + 10'd1;
        sy_d        = h_end ? (v_end ? 10'd0 : sy_q + 10'd1) : sy_q;
        frame_cnt_d = (h_end && v_end) ? frame_cnt_q + 16'd1 : frame_cnt_q;
        hs_raw      = (sx_q >= HS_START && sx_q < HS_END) ? SYNC_POL : ~SYNC_POL;
        vs_raw      = (sy_q >= VS_START && sy_q < VS_END) ? SYNC_POL : ~SYNC_POL;
    end

    always_ff @(posedge clk_25) begin
        if (rst) begin
            sx_q        <= 10'd0;
            sy_q        <= 10'd0;
            frame_cnt_q <= 16'd0;
        end else begin
            sx_q        <= sx_d;
            sy_q        <= sy_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign sx           = sx_q;
    assign sy           = sy_q;
    assign frame_cnt    = frame_cnt_q;
    assign active_pixel = sx_q < H_ACT && sy_q < V_ACT;
    assign line_start   = sx_q == 10'd0;
    assign frame_start  = sx_q == 10'd0 && sy_q == 10'd0;

    // Sync delay line keeps hsync/vsync aligned with the renderer's registered RGB.
    if (SYNC_DELAY == 0) begin : g_nodelay
        assign hsync = hs_raw;
        assign vsync = vs_raw;
    end else begin : g_delay
        logic [SYNC_DELAY-1:0] hs_q, hs_d, vs_q, vs_d;
        always_comb begin
            hs_d = SYNC_DELAY'({hs_q, hs_raw});
            vs_d = SYNC_DELAY'({vs_q, vs_raw});
        end
        always_ff @(posedge clk_25) begin
            if (rst) begin
                hs_q <= {SYNC_DELAY{~SYNC_POL}};
                vs_q <= {SYNC_DELAY{~SYNC_POL}};
            end else begin
                hs_q <= hs_d;
                vs_q <= vs_d;
            end
        end
        assign hsync = hs_q[SYNC_DELAY-1];
        assign vsync = vs_q[SYNC_DELAY-1];
    end

`ifdef VGA_TIMING_TEST_PATTERN_EN
    logic [11:0] tp_q, tp_d;
    logic [2:0]  bar;
    // Bar order white..black maps each channel onto one inverted bit of the bar index.
    always_comb begin
        bar  = 3'(sx_q / 10'(H_ACTIVE / 8));
        tp_d = active_pixel ? {{4{~bar[1]}}, {4{~bar[2]}}, {4{~bar[0]}}} : 12'h000;
    end
    always_ff @(posedge clk_25) begin
        if (rst) tp_q <= 12'h000;
        else     tp_q <= tp_d;
    end
    assign {tp_r, tp_g, tp_b} = tp_q;
`endif
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: scoreboard bench; a frame-position model predicts every cycle's outputs,
// counters are occasionally forced to jump near sync windows and frame boundaries.
module tb_vga_timing_gen;
    logic        clk_25 = 1'b0;
    logic        rst = 1'b1;
    logic [9:0]  sx, sy;
    logic        active_pixel, line_start, frame_start, hsync, vsync;
    logic [15:0] frame_cnt;
    logic [11:0] tp;

    always #20 clk_25 = ~clk_25;

`ifdef VGA_TIMING_TEST_PATTERN_EN
    logic [3:0] tp_r, tp_g, tp_b;
    assign tp = {tp_r, tp_g, tp_b};
`else
    assign tp = 12'h000;
`endif

    vga_timing_gen dut (
        .clk_25(clk_25),
        .rst(rst),
        .sx(sx),
        .sy(sy),
        .active_pixel(active_pixel),
        .line_start(line_start),
        .frame_start(frame_start),
        .hsync(hsync),
        .vsync(vsync),
`ifdef VGA_TIMING_TEST_PATTERN_EN
        .tp_r(tp_r),
        .tp_g(tp_g),
        .tp_b(tp_b),
`endif
        .frame_cnt(frame_cnt)
    );

    typedef struct {
        int x, y, fc, tp;
        bit act, ls, fs, hs, vs;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    // Model: linear position within a 420000-pixel frame plus a two-deep sync history.
    int pos = 0;
    int fc = 0;
    int tp_m = 0;
    bit hq[$];
    bit vq[$];
    int bars[8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000};

    task automatic step(input bit r);
        exp_t e;
        int x, y;
        x = pos % 800;
        y = pos / 800;
        if (r) begin
            pos = 0;
            fc = 0;
            tp_m = 0;
            hq = '{1'b1, 1'b1};
            vq = '{1'b1, 1'b1};
        end else begin
            hq.push_back(!(x >= 656 && x < 752));
            void'(hq.pop_front());
            vq.push_back(!(y >= 490 && y < 492));
            void'(vq.pop_front());
            tp_m = (x < 640 && y < 480) ? bars[x / 80] : 0;
            pos = pos + 1;
            if (pos == 420000) begin
                pos = 0;
                fc = (fc + 1) % 65536;
            end
        end
        x = pos % 800;
        y = pos / 800;
        e.x = x;
        e.y = y;
        e.fc = fc;
        e.tp = tp_m;
        e.act = x < 640 && y < 480;
        e.ls = x == 0;
        e.fs = pos == 0;
        e.hs = hq[0];
        e.vs = vq[0];
        sb.push_back(e);
    endtask

    // Called at a falling edge; drives rst for the next rising edge.
    task automatic tick(input bit r);
        rst = r;
        step(r);
        @(negedge clk_25);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick(1'b0);
    endtask

    task automatic jump(input int x, input int y, input int f);
        force dut.sx_q = 10'(x);
        force dut.sy_q = 10'(y);
        force dut.frame_cnt_q = 16'(f);
        #1;
        release dut.sx_q;
        release dut.sy_q;
        release dut.frame_cnt_q;
        pos = y * 800 + x;
        fc = f;
    endtask

    always @(posedge clk_25) begin
        exp_t e;
        bit tp_bad;
        #2;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            tp_bad = 1'b0;
`ifdef VGA_TIMING_TEST_PATTERN_EN
            tp_bad = int'(tp) != e.tp;
`endif
            checks++;
            if (int'(sx) != e.x || int'(sy) != e.y || int'(frame_cnt) != e.fc ||
                active_pixel != e.act || line_start != e.ls || frame_start != e.fs ||
                hsync != e.hs || vsync != e.vs || tp_bad) begin
                errors++;
                $display("FAIL cycle@%0t got sx=%0d sy=%0d act=%0b ls=%0b fs=%0b hs=%0b vs=%0b fc=%0d tp=%h exp sx=%0d sy=%0d act=%0b ls=%0b fs=%0b hs=%0b vs=%0b fc=%0d tp=%h",
                         $time, sx, sy, active_pixel, line_start, frame_start, hsync, vsync, frame_cnt, tp,
                         e.x, e.y, e.act, e.ls, e.fs, e.hs, e.vs, e.fc, e.tp[11:0]);
            end
        end
    end

    initial begin
        hq = '{1'b1, 1'b1};
        vq = '{1'b1, 1'b1};
        @(negedge clk_25);
        repeat (3) tick(1'b1);
        run(1700);
        jump(0, 488, 0);
        run(3300);
        jump(790, 524, 0);
        run(20);
        jump(795, 524, 65535);
        run(20);
        jump(300, 200, fc);
        tick(1'b1);
        run(10);
        jump(650, 3, 12);
        run(120);
        for (int k = 0; k < 10; k++) begin
            case ($urandom_range(0, 3))
                0: jump($urandom_range(0, 799), $urandom_range(0, 524), int'($urandom_range(0, 65535)));
                1: jump($urandom_range(780, 799), 524, $urandom_range(0, 1) ? 65535 : int'($urandom_range(0, 100)));
                2: jump($urandom_range(640, 760), $urandom_range(486, 494), int'($urandom_range(0, 65535)));
                default: repeat ($urandom_range(1, 3)) tick(1'b1);
            endcase
            run($urandom_range(1, 1500));
        end
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk_25);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending exp 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
